// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Two-requester write-back arbiter for a register file (ALU and
//               load unit) with starvation protection for the ALU, a
//               registered write port, and a pending-load scoreboard used for
//               source-register hazard detection.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (asserted when 0)
//   alu_valid    ALU write-back request
//   alu_rd/data  ALU destination register / result
//   alu_ready    ALU request accepted this cycle
//   lsu_valid    load-unit write-back request
//   lsu_rd/data  load destination register / data
//   lsu_ready    load request accepted this cycle
//   issue_valid  a load is issued; issue_rd becomes pending
//   issue_rd     destination register of the issued load
//   Rs1, Rs2     source registers checked for hazards
//   hazard       a source register has a pending load
//   WE, Rd, WD   registered register-file write port
//   busy_mask    pending-load scoreboard (bit 0 always 0)
// ============================================================================
module regfile_wb_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ready,
  input  logic             lsu_valid,
  input  logic [4:0]       lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  output logic             lsu_ready,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       Rs1,
  input  logic [4:0]       Rs2,
  output logic             hazard,
  output logic             WE,
  output logic [4:0]       Rd,
  output logic [WIDTH-1:0] WD,
  output logic [31:0]      busy_mask
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [3:0]  starve_nxt;
  logic        starved;
  logic        src_lsu;     // registered write came from the load unit
  logic [31:0] busy_set;
  logic [31:0] busy_clr;
  logic [31:0] busy_nxt;

  assign starved = (starve_cnt == LIMIT);

  // Grants are gated by reset so both readies drop the instant reset asserts.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (reset) begin
      alu_ready = alu_valid & (~lsu_valid | starved);
      lsu_ready = lsu_valid & ~(alu_valid & starved);
    end
  end

  // Count denied ALU cycles; any cycle without a pending denied ALU request
  // (idle or granted) restarts the count.
  always_comb begin
    starve_nxt = 4'd0;
    if (alu_valid && !alu_ready) begin
      starve_nxt = starved ? starve_cnt : starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  // Registered write port; Rd/WD hold when idle so only WE drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WE      <= 1'b0;
      Rd      <= 5'd0;
      WD      <= '0;
      src_lsu <= 1'b0;
    end else if (alu_ready) begin
      WE      <= (alu_rd != 5'd0);
      Rd      <= alu_rd;
      WD      <= alu_data;
      src_lsu <= 1'b0;
    end else if (lsu_ready) begin
      WE      <= (lsu_rd != 5'd0);
      Rd      <= lsu_rd;
      WD      <= lsu_data;
      src_lsu <= 1'b1;
    end else begin
      WE      <= 1'b0;
      src_lsu <= 1'b0;
    end
  end

  // Scoreboard: a pending bit clears on the edge the load's data is actually
  // written (registered WE from the LSU). A new issue on that edge wins.
  always_comb begin
    busy_set = 32'd0;
    busy_clr = 32'd0;
    if (issue_valid) begin
      busy_set[issue_rd] = 1'b1;
    end
    if (WE && src_lsu) begin
      busy_clr[Rd] = 1'b1;
    end
    busy_nxt    = (busy_mask & ~busy_clr) | busy_set;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_mask <= 32'd0;
    end else begin
      busy_mask <= busy_nxt;
    end
  end

  // Bit 0 of busy_mask is never set, so x0 sources cannot raise a hazard.
  assign hazard = busy_mask[Rs1] | busy_mask[Rs2];

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The module SHALL have these parameters:
- WIDTH, default 32, data width of the register file write port.
- STARVE_LIMIT, default 4, consecutive denied ALU cycles before ALU gets priority; legal range 1..15.

REQ-002 The module SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- alu_valid  in  1  ALU write-back request.
- alu_rd  in  5  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  load-unit write-back request.
- lsu_rd  in  5  load destination register.
- lsu_data  in  WIDTH  load data.
- lsu_ready  out  1  load request accepted this cycle.
- issue_valid  in  1  a load is issued; mark issue_rd pending.
- issue_rd  in  5  destination register of the issued load.
- Rs1, Rs2  in  5 each  source registers checked for hazards.
- hazard  out  1  a source register has a pending load.
- WE  out  1  register file write enable, registered.
- Rd  out  5  register file write address, registered.
- WD  out  WIDTH  register file write data, registered.
- busy_mask  out  32  pending-load scoreboard; bit 0 is always 0.

Function
REQ-003 A transfer SHALL occur on a rising edge where valid and ready are both 1 for a requester.
REQ-004 At most one of alu_ready and lsu_ready SHALL be 1 in any cycle.
REQ-005 A ready output SHALL be 1 only while its own valid is 1; ready is combinational from the valids and the starvation state.
REQ-006 Requesters SHALL hold valid, rd and data stable until transfer; the bench treats any violation as a protocol error.
REQ-007 Priority SHALL be fixed to LSU, except as set by REQ-008.
REQ-008 The ALU SHALL win when starve_cnt == STARVE_LIMIT and both requesters are valid.
REQ-009 starve_cnt SHALL behave as follows:
- Increments each cycle where alu_valid=1 and alu_ready=0.
- Saturates at STARVE_LIMIT.
- Clears to 0 on an ALU transfer or when alu_valid=0.
REQ-010 The edge after a transfer SHALL load WE=(rd!=0), Rd=rd and WD=data from the winner; latency is 1 cycle.
REQ-011 With no transfer, the next edge SHALL load WE=0 and hold Rd and WD.
REQ-012 A transfer with rd=0 SHALL complete the handshake but never assert WE.
REQ-013 busy_mask bit n SHALL be set on the edge where issue_valid=1 and issue_rd=n, for n!=0.
REQ-014 busy_mask bit n SHALL be cleared on the edge where the registered outputs are WE=1 and Rd=n with the source being the LSU, i.e. the same edge the register file is written.
REQ-015 The module SHALL track the LSU source of the registered write internally with a 1-bit register.
REQ-016 If a set and a clear of the same bit occur on the same edge, the set SHALL win.
REQ-017 hazard SHALL equal busy_mask[Rs1] | busy_mask[Rs2], combinational; Rs=0 never causes a hazard.
REQ-018 issue_valid for an rd that is already busy SHALL be an illegal input; the bit stays 1 and no counter is kept.
REQ-019 ALU transfers SHALL NOT modify busy_mask.

Reset
REQ-020 While reset=0, the module SHALL asynchronously force:
- WE=0, Rd=0, WD=0;
- busy_mask=0, starve_cnt=0, LSU-source flag=0;
- alu_ready=0 and lsu_ready=0.
REQ-021 Reset asserted mid-operation SHALL discard any registered write and all pending scoreboard bits.
REQ-022 The first transfer SHALL be possible on the first rising edge after reset returns to 1.

Verification
REQ-023 Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 the same cycle; next cycle WE=1, Rd=5, WD=0xDEADBEEF; the cycle after, WE=0.
REQ-024 Simultaneous requests: ALU rd=3 and LSU rd=7 both valid -> LSU is granted first with Rd=7; the ALU is granted the following cycle with Rd=3.
REQ-025 Starvation: lsu_valid held 1 continuously with STARVE_LIMIT=4 and alu_valid=1 -> ALU denied for 4 cycles, granted on the 5th, then starve_cnt=0.
REQ-026 Scoreboard:
- Stimulus: issue_valid with issue_rd=9, then Rs1=9.
- Required: hazard=1 and busy_mask=0x00000200.
- Then an LSU transfer with rd=9 -> busy bit 9 clears on the WE=1 edge and hazard drops the next cycle.
- Same-edge re-issue of rd=9 -> the bit stays 1.
REQ-027 x0 handling: LSU transfer with rd=0 -> lsu_ready=1 and WE stays 0; issue_rd=0 -> busy_mask stays 0.
REQ-028 Reset mid-operation:
- Stimulus: busy_mask=0x00000402 and WE=1, then reset pulled to 0 between clock edges.
- Required: all outputs are 0 immediately and stay 0 until the first edge after release.
